// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer and flush-to-bubble.
// Optional stall/flush counters are enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_stage #(
  parameter int DATA_W = 102,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_SKID_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  input  logic              flush
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e              state_q;
  logic                main_valid_q, skid_valid_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic                fire_in, fire_out;

  // Ready comes only from registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = !skid_valid_q && !flush && rst_n;
  assign fire_in   = in_valid && in_ready;
  assign fire_out  = main_valid_q && out_ready;

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
    end else if (flush) begin
      // Data is left in place; clearing ctrl is what turns the entries into bubbles.
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (fire_in) begin
            state_q      <= ONE;
            main_valid_q <= 1'b1;
            main_data_q  <= in_data;
            main_ctrl_q  <= in_ctrl;
          end
        end
        ONE: begin
          if (fire_in && fire_out) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end else if (fire_in) begin
            state_q      <= FULL;
            skid_valid_q <= 1'b1;
            skid_data_q  <= in_data;
            skid_ctrl_q  <= in_ctrl;
          end else if (fire_out) begin
            state_q      <= EMPTY;
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
          end
        end
        FULL: begin
          if (fire_out) begin
            state_q      <= ONE;
            main_data_q  <= skid_data_q;
            main_ctrl_q  <= skid_ctrl_q;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
          end
        end
        default: begin
          state_q      <= EMPTY;
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
          main_ctrl_q  <= '0;
          skid_ctrl_q  <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (main_valid_q && !out_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (main_valid_q || skid_valid_q) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, stats sequence (PIPE_SKID_STATS_EN),
// then random traffic checked against a queue-based FIFO model.
module tb_pipe_skid_stage;
  localparam int DW = 102;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready, flush;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
`ifdef PIPE_SKID_STATS_EN
  logic [31:0]   stall_cnt;
  logic [15:0]   flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
`ifdef PIPE_SKID_STATS_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .flush(flush)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          rn, iv;
    logic [31:0]   id;
    logic [CW-1:0] ic;
    logic          ordy, fl, eir, eov;
    logic [31:0]   eod;
    logic [CW-1:0] eoc;
    logic          cd;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic rn, iv, input logic [31:0] id, input logic [CW-1:0] ic,
                              input logic ordy, fl, eir, eov, input logic [31:0] eod,
                              input logic [CW-1:0] eoc, input logic cd);
    vec_t v;
    v.rn = rn; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy; v.fl = fl;
    v.eir = eir; v.eov = eov; v.eod = eod; v.eoc = eoc; v.cd = cd;
    tbl.push_back(v);
  endfunction

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;
  ent_t mq[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic          hold, exp_ov, exp_ir, fi, fo;
    logic [127:0]  rnd;
    logic [CW-1:0] exp_oc;
    ent_t          e;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0; flush = 1'b0;

    // rn iv id ic ordy fl | in_ready | out_valid out_data out_ctrl check_data
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 8; k++)
      add(1, 1, k, CW'(k), 1, 0, 1, 1, k, CW'(k), 1);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    // backpressure fill then drain
    add(1, 1, 32'h11, 6'h01, 0, 0, 1, 1, 32'h11, 6'h01, 1);
    add(1, 1, 32'h22, 6'h02, 0, 0, 1, 1, 32'h11, 6'h01, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1, 32'h11, 6'h01, 1);
    add(1, 0, 0, 0, 1, 0, 0, 1, 32'h22, 6'h02, 1);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    // flush while FULL; C is offered in the flush cycle and dropped
    add(1, 1, 32'hA1, 6'h3f, 0, 0, 1, 1, 32'hA1, 6'h3f, 1);
    add(1, 1, 32'hB2, 6'h3f, 0, 0, 1, 1, 32'hA1, 6'h3f, 1);
    add(1, 1, 32'hC3, 6'h3f, 0, 1, 0, 0, 32'hA1, 6'h00, 1);
    add(1, 0, 0, 0, 1, 0, 1, 0, 32'hA1, 6'h00, 1);
    // flush together with fire_out
    add(1, 1, 32'hD4, 6'h05, 0, 0, 1, 1, 32'hD4, 6'h05, 1);
    add(1, 0, 0, 0, 1, 1, 0, 0, 32'hD4, 6'h00, 1);
    add(1, 0, 0, 0, 1, 0, 1, 0, 32'hD4, 6'h00, 1);
    // reset while FULL
    add(1, 1, 32'hE5, 6'h21, 0, 0, 1, 1, 32'hE5, 6'h21, 1);
    add(1, 1, 32'hF6, 6'h12, 0, 0, 1, 1, 32'hE5, 6'h21, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 1, 32'h77, 6'h03, 1, 0, 1, 1, 32'h77, 6'h03, 1);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rn; in_valid = tbl[i].iv; in_data = DW'(tbl[i].id);
      in_ctrl = tbl[i].ic; out_ready = tbl[i].ordy; flush = tbl[i].fl;
      #1;
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].eir);
      tick();
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].eov);
      chk($sformatf("vec%0d out_ctrl", i), out_ctrl, tbl[i].eoc);
      if (tbl[i].cd)
        chk($sformatf("vec%0d out_data", i), out_data, DW'(tbl[i].eod));
    end

`ifdef PIPE_SKID_STATS_EN
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick();
    chk("stats reset stall_cnt", stall_cnt, 0);
    chk("stats reset flush_cnt", flush_cnt, 0);
    rst_n = 1'b1; in_valid = 1'b1; in_data = DW'(32'h55); in_ctrl = 6'h01;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("stats stall_cnt", stall_cnt, 5);
    chk("stats flush_cnt", flush_cnt, 1);
    chk("stats out_valid", out_valid, 0);
`endif

    mq.delete();
    hold = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_ov = (mq.size() > 0);
      exp_oc = exp_ov ? mq[0].c : '0;
      chk($sformatf("rnd%0d out_valid", cyc), out_valid, exp_ov);
      chk($sformatf("rnd%0d out_ctrl", cyc), out_ctrl, exp_oc);
      if (exp_ov)
        chk($sformatf("rnd%0d out_data", cyc), out_data, mq[0].d);

      rst_n     = (cyc == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rnd      = {$urandom, $urandom, $urandom, $urandom};
        in_data  = rnd[DW-1:0];
        in_ctrl  = CW'($urandom);
      end
      #1;
      exp_ir = rst_n && !flush && (mq.size() < 2);
      chk($sformatf("rnd%0d in_ready", cyc), in_ready, exp_ir);
      fi   = in_valid && exp_ir;
      fo   = exp_ov && out_ready;
      hold = in_valid && !fi && !flush && rst_n;
      e.d  = in_data;
      e.c  = in_ctrl;
      tick();
      if (!rst_n) mq.delete();
      else begin
        if (fo) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (fi) mq.push_back(e);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
